// File: rtl/lsu_nbload_cam.sv
// Outstanding non-blocking load tracker: tag alloc, writeback, cancel, hazards.
// Optional FP destination tracking is enabled by defining RV_NBLOAD_FP_EN.
module lsu_nbload_cam #(
  parameter  int DEPTH = 4,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
`ifdef RV_NBLOAD_FP_EN
  input  logic             alloc_fp,
`endif
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cancel_valid,
  input  logic [TAG_W-1:0] cancel_tag,
  input  logic             resp_valid,
  input  logic [TAG_W-1:0] resp_tag,
  input  logic             resp_error,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [4:0]       wb_rd,
  output logic             wb_fp,
  output logic             wb_error,
  input  logic [4:0]       chk_rd0,
  input  logic [4:0]       chk_rd1,
`ifdef RV_NBLOAD_FP_EN
  input  logic             chk_fp0,
  input  logic             chk_fp1,
`endif
  output logic             hazard0,
  output logic             hazard1,
  output logic [TAG_W:0]   outstanding,
  output logic             full,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    S_FREE,
    S_PEND,
    S_KILLED,
    S_WB
  } ent_st_e;

  ent_st_e    st_q [DEPTH];
  ent_st_e    st_d [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [4:0] rd_d [DEPTH];
`ifdef RV_NBLOAD_FP_EN
  logic       fp_q [DEPTH];
  logic       fp_d [DEPTH];
  logic       resp_fp;
  logic       wb_fp_q, wb_fp_d;
`endif

  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_error_q, wb_error_d;
  logic             proto_err_q, proto_err_d;

  ent_st_e          resp_st;
  logic [4:0]       resp_rd;
  logic             alloc_fire;
  logic             kill_resp;
  logic             wb_fire;
  logic [DEPTH-1:0] a_hit, c_hit, r_hit;

  // Status outputs depend on registered state only.
  always_comb begin
    alloc_tag   = '0;
    outstanding = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        alloc_tag = TAG_W'(i);
      end else begin
        outstanding = outstanding + (TAG_W+1)'(1);
      end
    end
    full        = (outstanding == (TAG_W+1)'(DEPTH));
    alloc_ready = !full;
  end

  always_comb begin
    resp_st = S_FREE;
    resp_rd = '0;
`ifdef RV_NBLOAD_FP_EN
    resp_fp = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (resp_tag == TAG_W'(i)) begin
        resp_st = st_q[i];
        resp_rd = rd_q[i];
`ifdef RV_NBLOAD_FP_EN
        resp_fp = fp_q[i];
`endif
      end
    end
  end

  always_comb begin
    alloc_fire = alloc_valid && alloc_ready;
    kill_resp  = cancel_valid && resp_valid && (cancel_tag == resp_tag);
    wb_fire    = resp_valid && (resp_st == S_PEND) && !kill_resp;
    st_d       = st_q;
    rd_d       = rd_q;
`ifdef RV_NBLOAD_FP_EN
    fp_d       = fp_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      a_hit[i] = alloc_fire && (alloc_tag == TAG_W'(i));
      c_hit[i] = cancel_valid && (cancel_tag == TAG_W'(i));
      r_hit[i] = resp_valid && (resp_tag == TAG_W'(i));
      unique case (st_q[i])
        S_FREE: begin
          if (a_hit[i]) begin
            st_d[i] = S_PEND;
            rd_d[i] = alloc_rd;
`ifdef RV_NBLOAD_FP_EN
            fp_d[i] = alloc_fp;
`endif
          end
        end
        S_PEND: begin
          // A cancel racing its own response retires the entry silently.
          if (c_hit[i]) begin
            st_d[i] = r_hit[i] ? S_FREE : S_KILLED;
          end else if (r_hit[i]) begin
            st_d[i] = S_WB;
          end
        end
        S_KILLED: begin
          if (r_hit[i]) st_d[i] = S_FREE;
        end
        S_WB: st_d[i] = S_FREE;
        default: st_d[i] = S_FREE;
      endcase
    end
  end

  always_comb begin
    proto_err_d = proto_err_q
                | (alloc_valid && !alloc_ready)
                | (resp_valid && ((resp_st == S_FREE)
                                || (resp_st == S_WB)));
    wb_valid_d = wb_fire;
    wb_tag_d   = wb_tag_q;
    wb_rd_d    = wb_rd_q;
    wb_error_d = wb_error_q;
`ifdef RV_NBLOAD_FP_EN
    wb_fp_d    = wb_fp_q;
`endif
    if (wb_fire) begin
      wb_tag_d   = resp_tag;
      wb_rd_d    = resp_rd;
      wb_error_d = resp_error;
`ifdef RV_NBLOAD_FP_EN
      wb_fp_d    = resp_fp;
`endif
    end
  end

  always_comb begin
    hazard0 = 1'b0;
    hazard1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((st_q[i] == S_PEND) || (st_q[i] == S_WB)) begin
`ifdef RV_NBLOAD_FP_EN
        // x0 is hardwired, but f0 is a real register.
        if ((rd_q[i] == chk_rd0) && (fp_q[i] == chk_fp0)
            && (fp_q[i] || (rd_q[i] != 5'd0))) hazard0 = 1'b1;
        if ((rd_q[i] == chk_rd1) && (fp_q[i] == chk_fp1)
            && (fp_q[i] || (rd_q[i] != 5'd0))) hazard1 = 1'b1;
`else
        if ((rd_q[i] == chk_rd0) && (rd_q[i] != 5'd0)) hazard0 = 1'b1;
        if ((rd_q[i] == chk_rd1) && (rd_q[i] != 5'd0)) hazard1 = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= S_FREE;
        rd_q[i] <= '0;
`ifdef RV_NBLOAD_FP_EN
        fp_q[i] <= 1'b0;
`endif
      end
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_rd_q     <= '0;
      wb_error_q  <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef RV_NBLOAD_FP_EN
      wb_fp_q     <= 1'b0;
`endif
    end else begin
      st_q        <= st_d;
      rd_q        <= rd_d;
`ifdef RV_NBLOAD_FP_EN
      fp_q        <= fp_d;
      wb_fp_q     <= wb_fp_d;
`endif
      wb_valid_q  <= wb_valid_d;
      wb_tag_q    <= wb_tag_d;
      wb_rd_q     <= wb_rd_d;
      wb_error_q  <= wb_error_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_tag    = wb_tag_q;
  assign wb_rd     = wb_rd_q;
  assign wb_error  = wb_error_q;
  assign proto_err = proto_err_q;
`ifdef RV_NBLOAD_FP_EN
  assign wb_fp     = wb_fp_q;
`else
  assign wb_fp     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_nbload_cam.sv
// Directed table-driven bench for lsu_nbload_cam (DEPTH=4).
// Vectors are driven after a rising edge and checked on the falling edge.
module tb_lsu_nbload_cam;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [4:0] alloc_rd;
  logic       alloc_ready;
  logic [1:0] alloc_tag;
  logic       cancel_valid;
  logic [1:0] cancel_tag;
  logic       resp_valid;
  logic [1:0] resp_tag;
  logic       resp_error;
  logic       wb_valid;
  logic [1:0] wb_tag;
  logic [4:0] wb_rd;
  logic       wb_fp;
  logic       wb_error;
  logic [4:0] chk_rd0, chk_rd1;
  logic       hazard0, hazard1;
  logic [2:0] outstanding;
  logic       full;
  logic       proto_err;
`ifdef RV_NBLOAD_FP_EN
  logic       alloc_fp;
  logic       chk_fp0, chk_fp1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_nbload_cam #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
`ifdef RV_NBLOAD_FP_EN
    .alloc_fp     (alloc_fp),
`endif
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cancel_valid (cancel_valid),
    .cancel_tag   (cancel_tag),
    .resp_valid   (resp_valid),
    .resp_tag     (resp_tag),
    .resp_error   (resp_error),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_rd        (wb_rd),
    .wb_fp        (wb_fp),
    .wb_error     (wb_error),
    .chk_rd0      (chk_rd0),
    .chk_rd1      (chk_rd1),
`ifdef RV_NBLOAD_FP_EN
    .chk_fp0      (chk_fp0),
    .chk_fp1      (chk_fp1),
`endif
    .hazard0      (hazard0),
    .hazard1      (hazard1),
    .outstanding  (outstanding),
    .full         (full),
    .proto_err    (proto_err)
  );

  typedef struct {
    logic       rst;
    logic       av;
    logic [4:0] ard;
    logic       cv;
    logic [1:0] ct;
    logic       rv;
    logic [1:0] rt;
    logic       re;
    logic [4:0] c0;
    logic [4:0] c1;
    logic       rdy;
    logic [1:0] atag;
    logic       full;
    logic [2:0] outs;
    logic       h0;
    logic       h1;
    logic       wbv;
    logic [1:0] wbt;
    logic [4:0] wbr;
    logic       wbe;
    logic       perr;
    logic       wbz;
  } vec_t;

  vec_t vt [36];

  function automatic vec_t mk(
    input int rs, av, ard, cv, ct, rv, rt, re, c0, c1,
    input int rdy, atag, fl, outs, h0, h1, wbv, wbt, wbr, wbe, perr, wbz);
    vec_t v;
    v.rst = rs[0]; v.av = av[0]; v.ard = ard[4:0];
    v.cv = cv[0]; v.ct = ct[1:0]; v.rv = rv[0]; v.rt = rt[1:0];
    v.re = re[0]; v.c0 = c0[4:0]; v.c1 = c1[4:0];
    v.rdy = rdy[0]; v.atag = atag[1:0]; v.full = fl[0];
    v.outs = outs[2:0]; v.h0 = h0[0]; v.h1 = h1[0];
    v.wbv = wbv[0]; v.wbt = wbt[1:0]; v.wbr = wbr[4:0];
    v.wbe = wbe[0]; v.perr = perr[0]; v.wbz = wbz[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
    cancel_valid = 1'b0; cancel_tag = '0;
    resp_valid = 1'b0; resp_tag = '0; resp_error = 1'b0;
    chk_rd0 = '0; chk_rd1 = '0;
`ifdef RV_NBLOAD_FP_EN
    alloc_fp = 1'b0; chk_fp0 = 1'b0; chk_fp1 = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //         rs av ard cv ct rv rt re c0 c1   rdy at fl out h0 h1 wbv wbt wbr wbe pe wbz
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[1]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 6, 0, 0, 0, 0, 0, 5, 6,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 7, 0, 0, 0, 0, 0, 6, 7,  1, 2, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 8, 0, 0, 0, 0, 0, 7, 8,  1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 1, 9, 0, 0, 0, 0, 0, 8, 9,  0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 7, 5,  0, 0, 1, 4, 1, 1, 1, 2, 7, 0, 1, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 7, 5,  1, 2, 0, 3, 0, 1, 1, 0, 5, 1, 1, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 6,  1, 0, 0, 2, 0, 1, 1, 1, 6, 0, 1, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 1, 3, 0, 6, 8,  1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8,  1, 0, 0, 1, 0, 1, 1, 3, 8, 0, 1, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[15] = mk(0, 1,10, 0, 0, 0, 0, 0,10, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,10, 0,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,10, 0,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 1, 0, 0,10, 0,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,10, 0,  1, 1, 0, 1, 1, 0, 1, 0,10, 0, 0, 0);
    vt[20] = mk(0, 1,11, 0, 0, 0, 0, 0,10, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[21] = mk(0, 1,12, 0, 0, 0, 0, 0,11,12,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[22] = mk(0, 0, 0, 1, 1, 1, 1, 0,11,12,  1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[23] = mk(0, 0, 0, 1, 0, 0, 0, 0,11,12,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[24] = mk(0, 0, 0, 0, 0, 1, 0, 0,11, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[25] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[26] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[28] = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[29] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[30] = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[31] = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[32] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 3,  1, 3, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0);
    vt[33] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[35] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    do_reset();

    for (int i = 0; i < 36; i++) begin
      idle_in();
      rst = vt[i].rst; alloc_valid = vt[i].av; alloc_rd = vt[i].ard;
      cancel_valid = vt[i].cv; cancel_tag = vt[i].ct;
      resp_valid = vt[i].rv; resp_tag = vt[i].rt; resp_error = vt[i].re;
      chk_rd0 = vt[i].c0; chk_rd1 = vt[i].c1;
      @(negedge clk);
      chk($sformatf("v%0d.alloc_ready", i), int'(alloc_ready), int'(vt[i].rdy));
      if (vt[i].rdy)
        chk($sformatf("v%0d.alloc_tag", i), int'(alloc_tag), int'(vt[i].atag));
      chk($sformatf("v%0d.full", i), int'(full), int'(vt[i].full));
      chk($sformatf("v%0d.outstanding", i), int'(outstanding), int'(vt[i].outs));
      chk($sformatf("v%0d.hazard0", i), int'(hazard0), int'(vt[i].h0));
      chk($sformatf("v%0d.hazard1", i), int'(hazard1), int'(vt[i].h1));
      chk($sformatf("v%0d.wb_valid", i), int'(wb_valid), int'(vt[i].wbv));
      chk($sformatf("v%0d.proto_err", i), int'(proto_err), int'(vt[i].perr));
      if (vt[i].wbv || vt[i].wbz) begin
        chk($sformatf("v%0d.wb_tag", i), int'(wb_tag), int'(vt[i].wbt));
        chk($sformatf("v%0d.wb_rd", i), int'(wb_rd), int'(vt[i].wbr));
        chk($sformatf("v%0d.wb_error", i), int'(wb_error), int'(vt[i].wbe));
        chk($sformatf("v%0d.wb_fp", i), int'(wb_fp), 0);
      end
      tick();
    end

    // Entry in writeback is not yet reusable: alloc in that cycle is refused.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1'b1;
      alloc_rd = 5'(20 + k);
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("seq.full4", int'(full), 1);
    resp_valid = 1'b1;
    resp_tag = 2'd1;
    tick();
    idle_in();
    alloc_valid = 1'b1;
    alloc_rd = 5'd30;
    @(negedge clk);
    chk("seq.ready_in_wb", int'(alloc_ready), 0);
    chk("seq.wb_valid", int'(wb_valid), 1);
    chk("seq.wb_rd", int'(wb_rd), 21);
    tick();
    idle_in();
    chk_rd0 = 5'd30;
    @(negedge clk);
    chk("seq.proto_err", int'(proto_err), 1);
    chk("seq.outstanding", int'(outstanding), 3);
    chk("seq.alloc_tag", int'(alloc_tag), 1);
    chk("seq.hazard_rd30", int'(hazard0), 0);
    tick();

`ifdef RV_NBLOAD_FP_EN
    do_reset();
    alloc_valid = 1'b1;
    alloc_rd = 5'd0;
    alloc_fp = 1'b1;
    tick();
    idle_in();
    chk_rd0 = 5'd0;
    chk_fp0 = 1'b1;
    @(negedge clk);
    chk("fp.f0_hazard", int'(hazard0), 1);
    chk_fp0 = 1'b0;
    #1;
    chk("fp.x0_no_hazard", int'(hazard0), 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_nbload_cam.md
# lsu_nbload_cam

Parametrised tracker for outstanding non-blocking loads in the LSU. It allocates a tag per issued load, records the destination register, and returns the tag/rd pair as a registered writeback request when the bus data arrives. It drops writeback for loads cancelled by a flush, and supplies decode with per-source register-hazard flags. It sits between the LSU bus interface and the decode scoreboard, and generalises the fixed-depth, integer-only load CAM to DEPTH entries, optional FP destinations, and cancellation.

## Interface
- DEPTH, 4, number of entries, 2..16
- TAG_W, $clog2(DEPTH), tag width, derived, not overridden
- clk  in  1  core clock
- rst  in  1  reset; synchronous and active-high
- alloc_valid  in  1  allocate an entry for a non-blocking load this cycle
- alloc_rd  in  5  destination register
- alloc_fp  in  1  destination is FP register file (RV_NBLOAD_FP_EN only)
- alloc_ready  out  1  a FREE entry exists
- alloc_tag  out  TAG_W  lowest-index FREE entry
- cancel_valid, cancel_tag  in  1, TAG_W  kill an outstanding load (flush)
- resp_valid, resp_tag, resp_error  in  1, TAG_W, 1  bus data return
- wb_valid, wb_tag, wb_rd, wb_fp, wb_error  out  1, TAG_W, 5, 1, 1  registered writeback request
- chk_rd0, chk_rd1  in  5  decode source registers
- chk_fp0, chk_fp1  in  1  source is FP (RV_NBLOAD_FP_EN only)
- hazard0, hazard1  out  1  source matches an unwritten load destination
- outstanding  out  TAG_W+1  count of non-FREE entries
- full  out  1  no FREE entry
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Per-entry state: FREE, PEND, KILLED, WB. Fields: rd[4:0], fp, err.
- FREE -> PEND on alloc_valid && alloc_ready, at entry alloc_tag. rd and fp are captured.
- PEND -> KILLED on cancel_valid with a matching tag.
- PEND -> WB on resp_valid with a matching tag. wb_* are registered from the entry; wb_error = resp_error.
- KILLED -> FREE on a matching response. No writeback is issued.
- WB -> FREE after exactly one cycle. wb_valid is high only during WB, and at most one entry is in WB per cycle, because at most one response arrives per cycle.
- Simultaneous cancel and resp on the same PEND tag: cancel wins. The entry goes to FREE and no writeback is issued.
- Cancel on a FREE or WB entry is ignored.
- A response to a FREE or WB entry is ignored and sets proto_err.
- alloc_valid while full is ignored and sets proto_err.
- proto_err is cleared only by rst.
- Hazard rule: hazardN = OR over entries in PEND or WB of (rd == chk_rdN && fp == chk_fpN).
  - Integer rd 0 never matches.
  - FP f0 does match.
  - KILLED entries never match.
- outstanding counts PEND, KILLED and WB entries. full = (outstanding == DEPTH).

## Timing
- alloc_ready, alloc_tag, full, hazard0/1 and outstanding are combinational from registered state only. They have no input-to-output paths except chk_* -> hazard*.
- Allocation at cycle t: the entry is PEND at t+1 and hazards are visible at t+1.
- Response at cycle t: wb_valid is high at t+1 and the entry is FREE at t+2.
- An entry freed in a cycle is not allocatable in that same cycle.
- Reset, including mid-operation:
  - All entries go FREE.
  - wb_valid=0, wb_tag=0, wb_rd=0, wb_fp=0, wb_error=0.
  - proto_err=0, outstanding=0, full=0, alloc_ready=1, alloc_tag=0, hazard0/1=0.
  - Responses arriving after reset for pre-reset tags set proto_err.

## Configuration
- RV_NBLOAD_FP_EN defined:
  - The alloc_fp and chk_fp* ports exist.
  - Each entry stores fp.
  - Hazard matching includes fp equality, and FP f0 is trackable.
- RV_NBLOAD_FP_EN undefined:
  - The fp ports are absent and the fp field is not stored.
  - wb_fp is tied 0.
  - All destinations are integer and rd 0 never hazards.

## Test plan
- DEPTH=4: allocate rd 5,6,7,8 on consecutive cycles -> alloc_tag 0,1,2,3; full=1 and outstanding=4 at cycle 4; a fifth alloc sets proto_err=1.
- Alloc rd 10 at t, resp tag 0 at t+3 -> hazard on chk_rd0=10 at t+1..t+4; wb_valid=1, wb_rd=10 at t+4; hazard=0 and alloc_ready at t+5.
- Alloc tag 1, then cancel tag 1 and resp tag 1 in the same cycle -> no wb_valid; entry FREE next cycle; proto_err stays 0.
- Alloc rd 0 (integer) with chk_rd0=0 -> hazard0=0. With RV_NBLOAD_FP_EN, alloc f0 with chk_rd0=0, chk_fp0=1 -> hazard0=1; with chk_fp0=0 -> hazard0=0.
- Out-of-order responses: tags 2,0,1 returned on back-to-back cycles -> wb_tag 2,0,1 on consecutive cycles with matching rd; a resp_error on tag 0 gives wb_error=1 only for that writeback.
- Three entries outstanding, assert rst for 1 cycle -> every reset value is met the next cycle; a stale resp tag 1 then sets proto_err=1 and produces no wb_valid.
